// File: rtl/spdif_pkg.sv
// spdif_pkg: rate encoding, half-bit table and run-length class bounds shared by the S/PDIF rate tracker
package spdif_pkg;
  localparam int RUN_W = 6;
  localparam logic [RUN_W-1:0] RUN_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_MIN = 6'd3;
  localparam logic [RUN_W-1:0] HI_192K = 6'd5;
  localparam logic [RUN_W-1:0] HI_96K = 6'd11;
  localparam logic [RUN_W-1:0] HI_48K = 6'd16;
  localparam logic [RUN_W-1:0] HI_44K = 6'd20;
  localparam logic [RUN_W-1:0] HI_32K = 6'd28;
  localparam logic [RUN_W-1:0] HB_32K = 6'd24;
  localparam logic [RUN_W-1:0] HB_44K = 6'd18;
  localparam logic [RUN_W-1:0] HB_48K = 6'd16;
  localparam logic [RUN_W-1:0] HB_96K = 6'd8;
  localparam logic [RUN_W-1:0] HB_192K = 6'd4;
  typedef enum logic [2:0] {R32K, R44K, R48K, R96K, R192K} rate_e;
  typedef enum logic [1:0] {MEASURE, CONFIRM, LOCKWAIT, TRACK} state_e;
  typedef struct packed {
    logic  match;
    rate_e rate;
  } class_t;
  function automatic class_t classify(input logic [RUN_W-1:0] run);
    class_t c;
    c.match = run >= RUN_MIN && run <= HI_32K;
    c.rate = run <= HI_192K ? R192K : run <= HI_96K ? R96K : run <= HI_48K ? R48K :
             run <= HI_44K ? R44K : R32K;
    return c;
  endfunction
  function automatic logic [RUN_W-1:0] halfbit(input rate_e r);
    return r == R32K ? HB_32K : r == R44K ? HB_44K : r == R48K ? HB_48K : r == R96K ? HB_96K : HB_192K;
  endfunction
endpackage

// File: rtl/spdif_runlen_meter.sv
// spdif_runlen_meter: synchronises the line, measures edge-to-edge runs and reports the shortest valid run per window
module spdif_runlen_meter
  import spdif_pkg::*;
#(
  parameter int WINDOW_LOG2 = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic             signal_i,
  output logic             win_done,
  output logic [RUN_W-1:0] min_run
);
  logic [2:0] sync;
  logic [1:0] arm;
  logic [RUN_W-1:0] run_cnt, win_min, next_min;
  logic [WINDOW_LOG2-1:0] win_cnt;
  logic tog, run_ok;
  assign tog = sync[2] ^ sync[1];
  // the run ending at the second edge after reset may start at a synchroniser artefact, so only later runs count
  assign run_ok = tog && arm[1] && run_cnt >= RUN_MIN && run_cnt < win_min;
  assign next_min = run_ok ? run_cnt : win_min;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      arm <= '0;
      run_cnt <= '0;
      win_cnt <= '0;
      win_min <= RUN_MAX;
      win_done <= 1'b0;
      min_run <= RUN_MAX;
    end else begin
      sync <= {sync[1:0], signal_i};
      arm <= tog && !arm[1] ? arm + 1'b1 : arm;
      run_cnt <= tog ? RUN_W'(1) : run_cnt == RUN_MAX ? run_cnt : run_cnt + 1'b1;
      win_cnt <= restart ? '0 : win_cnt + 1'b1;
      win_done <= !restart && &win_cnt;
      win_min <= restart || &win_cnt ? RUN_MAX : next_min;
      min_run <= &win_cnt ? next_min : min_run;
    end
  end
endmodule

// File: rtl/spdif_rate_tracker.sv
// spdif_rate_tracker: detects the S/PDIF sample rate from the line run lengths and configures/relocks the decoder
module spdif_rate_tracker
  import spdif_pkg::*;
#(
  parameter int WINDOW_LOG2 = 12,
  parameter int LOCK_TIMEOUT_LOG2 = 14,
  parameter int MAX_CLK_PER_HALFBIT_LOG2 = 5,
  parameter int NUM_RATE = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                signal_i,
  input  logic                                locked_i,
  output logic [MAX_CLK_PER_HALFBIT_LOG2-1:0] clk_per_halfbit_o,
  output logic [NUM_RATE-1:0]                 rate_o,
  output logic                                relock_o,
  output logic                                valid_o
);
  localparam int CW = MAX_CLK_PER_HALFBIT_LOG2;
  state_e state;
  rate_e cls;
  class_t cur;
  logic [LOCK_TIMEOUT_LOG2-1:0] tmo_cnt;
  logic [RUN_W-1:0] min_run;
  logic win_done, to_measure;
  assign cur = classify(min_run);
  // every entry to MEASURE starts a fresh window in the meter
  assign to_measure = state == CONFIRM ? win_done && !cur.match :
                      state == LOCKWAIT ? !locked_i && &tmo_cnt :
                      state == TRACK ? !locked_i : 1'b0;
  spdif_runlen_meter #(.WINDOW_LOG2(WINDOW_LOG2)) u_meter (
    .clk(clk),
    .rst_n(rst_n),
    .restart(to_measure),
    .signal_i(signal_i),
    .win_done(win_done),
    .min_run(min_run)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MEASURE;
      cls <= R32K;
      tmo_cnt <= '0;
      clk_per_halfbit_o <= CW'(halfbit(R192K));
      rate_o <= NUM_RATE'(1) << R192K;
      relock_o <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      relock_o <= 1'b0;
      case (state)
        MEASURE: begin
          if (win_done && cur.match) begin
            cls <= cur.rate;
            state <= CONFIRM;
          end
        end
        CONFIRM: begin
          if (win_done && !cur.match) state <= MEASURE;
          else if (win_done && cur.rate == cls) begin
            clk_per_halfbit_o <= CW'(halfbit(cur.rate));
            rate_o <= NUM_RATE'(1) << cur.rate;
            relock_o <= 1'b1;
            tmo_cnt <= '0;
            state <= LOCKWAIT;
          end else if (win_done) cls <= cur.rate;
        end
        LOCKWAIT: begin
          if (locked_i) begin
            valid_o <= 1'b1;
            state <= TRACK;
          end else if (&tmo_cnt) state <= MEASURE;
          else tmo_cnt <= tmo_cnt + 1'b1;
        end
        TRACK: begin
          if (!locked_i) begin
            valid_o <= 1'b0;
            state <= MEASURE;
          end
        end
        default: state <= MEASURE;
      endcase
    end
  end
endmodule

// File: tb/tb_spdif_rate_tracker.sv
// tb_spdif_rate_tracker: biphase line generator, relock scoreboard and rate table checks
module tb_spdif_rate_tracker;
  localparam int W = 512;
  typedef struct packed {
    logic [4:0] cph;
    logic [4:0] rate;
  } exp_t;
  typedef struct {
    int hb;
    int cph;
    int rate;
    bit match;
  } vec_t;
  logic clk = 0, rst_n = 0, locked_i = 0, line = 0, glitch = 0;
  logic signal_i, relock, valid;
  logic [4:0] cph, rate;
  int hb = 0, checks = 0, errors = 0, relocks = 0, cyc = 0, last_relock = 0, rel_cyc = 0;
  bit gl_en = 0, prev_relock = 0;
  exp_t sb[$];
  vec_t tbl[10];

  assign signal_i = line ^ glitch;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spdif_rate_tracker #(.WINDOW_LOG2(9), .LOCK_TIMEOUT_LOG2(14), .MAX_CLK_PER_HALFBIT_LOG2(5), .NUM_RATE(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .signal_i(signal_i),
    .locked_i(locked_i),
    .clk_per_halfbit_o(cph),
    .rate_o(rate),
    .relock_o(relock),
    .valid_o(valid)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input int c, input int r);
    exp_t e;
    e.cph = 5'(c);
    e.rate = 5'(r);
    sb.push_back(e);
  endtask

  task automatic do_reset(input int new_hb);
    rst_n = 0;
    locked_i = 0;
    gl_en = 0;
    hb = new_hb;
    step(70);
    rst_n = 1;
    rel_cyc = cyc;
  endtask

  task automatic wait_relock(input string name, input int budget);
    int r0, n;
    r0 = relocks;
    n = 0;
    while (relocks == r0 && n < budget) begin
      step(1);
      n++;
    end
    chk(name, relocks - r0, 1);
  endtask

  // biphase-mark line: toggle at every bit start, and again mid-bit for a one
  initial begin
    int h, nb;
    bit b;
    nb = 0;
    forever begin
      if (hb == 0) @(negedge clk);
      else begin
        h = hb;
        b = (nb % 3 == 0) || ($urandom_range(0, 1) == 1);
        nb++;
        line = ~line;
        repeat (h) @(negedge clk);
        if (b) line = ~line;
        repeat (h) @(negedge clk);
      end
    end
  end

  initial forever begin
    repeat (97) @(negedge clk);
    if (gl_en) begin
      glitch = 1;
      @(negedge clk);
      glitch = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    chk("rate_onehot", int'($onehot(rate)), 1);
    if (relock) begin
      relocks++;
      last_relock = cyc;
      if (prev_relock) begin
        checks++;
        errors++;
        $display("FAIL relock_width: relock_o high for more than one cycle");
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_relock: cph=%0d rate=%b with no expected entry", cph, rate);
      end else begin
        e = sb.pop_front();
        chk("relock_cph", int'(cph), int'(e.cph));
        chk("relock_rate", int'(rate), int'(e.rate));
      end
    end
    prev_relock = relock;
  end

  initial begin
    int r0, r1;
    tbl = '{'{3, 4, 16, 1}, '{5, 4, 16, 1}, '{6, 8, 8, 1}, '{11, 8, 8, 1}, '{12, 16, 4, 1},
            '{17, 18, 2, 1}, '{20, 18, 2, 1}, '{21, 24, 1, 1}, '{28, 24, 1, 1}, '{29, 0, 0, 0}};
    step(3);
    chk("rst_cph", int'(cph), 4);
    chk("rst_rate", int'(rate), 16);
    chk("rst_relock", int'(relock), 0);
    chk("rst_valid", int'(valid), 0);
    do_reset(16);
    push_exp(16, 4);
    wait_relock("lock48k", 4 * W);
    chk_rng("lock48k_latency", last_relock - rel_cyc, 2 * W, 2 * W + 8);
    chk("lockwait_valid", int'(valid), 0);
    locked_i = 1;
    step(1);
    chk("track_valid", int'(valid), 1);
    r0 = relocks;
    step(2 * W);
    chk("track_ignores_windows", relocks - r0, 0);
    chk("track_valid_held", int'(valid), 1);
    locked_i = 0;
    step(1);
    chk("unlock_valid", int'(valid), 0);
    for (int i = 0; i < 10; i++) begin
      do_reset(tbl[i].hb);
      if (tbl[i].match) begin
        push_exp(tbl[i].cph, tbl[i].rate);
        wait_relock($sformatf("tbl_hb%0d_lock", tbl[i].hb), 4 * W);
      end else begin
        r0 = relocks;
        step(3 * W);
        chk($sformatf("tbl_hb%0d_nomatch", tbl[i].hb), relocks - r0, 0);
      end
    end
    do_reset(0);
    r0 = relocks;
    step(3 * W);
    chk("idle_relocks", relocks - r0, 0);
    chk("idle_cph", int'(cph), 4);
    chk("idle_rate", int'(rate), 16);
    chk("idle_valid", int'(valid), 0);
    do_reset(18);
    push_exp(24, 1);
    step(W - 100);
    hb = 24;
    wait_relock("lock32k", 5 * W);
    chk_rng("lock32k_latency", last_relock - rel_cyc, 3 * W, 3 * W + 8);
    r0 = relocks;
    step(W);
    chk("lock32k_single", relocks - r0, 0);
    do_reset(8);
    push_exp(8, 8);
    push_exp(8, 8);
    wait_relock("lock96k", 4 * W);
    r1 = last_relock;
    r0 = relocks;
    step(16000);
    chk("lockwait_hold", relocks - r0, 0);
    chk("lockwait_cph", int'(cph), 8);
    wait_relock("relock96k_timeout", 3000);
    chk_rng("timeout_interval", last_relock - r1, 16384 + 2 * W - 4, 16384 + 2 * W + 8);
    do_reset(4);
    push_exp(4, 16);
    wait_relock("lock192k", 4 * W);
    locked_i = 1;
    step(1);
    chk("track192k_valid", int'(valid), 1);
    step(50);
    locked_i = 0;
    gl_en = 1;
    push_exp(4, 16);
    step(1);
    chk("drop_valid", int'(valid), 0);
    wait_relock("relock192k_glitch", 4 * W);
    gl_en = 0;
    do_reset(8);
    push_exp(8, 8);
    wait_relock("lock96k_b", 4 * W);
    step(100);
    r0 = relocks;
    rst_n = 0;
    #1;
    chk("async_rst_cph", int'(cph), 4);
    chk("async_rst_rate", int'(rate), 16);
    chk("async_rst_relock", int'(relock), 0);
    chk("async_rst_valid", int'(valid), 0);
    step(20);
    rst_n = 1;
    step(W / 2);
    chk("post_rst_relocks", relocks - r0, 0);
    chk("post_rst_cph", int'(cph), 4);
    hb = 0;
    step(10);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spdif_rate_tracker.md
SPDIF_RATE_TRACKER -- requirements
Module: spdif_rate_tracker

Interface
REQ-001 SHALL have parameter WINDOW_LOG2, default 12, measurement window length 2^WINDOW_LOG2 clocks.
REQ-002 SHALL have parameter LOCK_TIMEOUT_LOG2, default 14, maximum wait for receiver lock 2^LOCK_TIMEOUT_LOG2 clocks.
REQ-003 SHALL have parameter MAX_CLK_PER_HALFBIT_LOG2, default 5, width of the half-bit period output.
REQ-004 SHALL have parameter NUM_RATE, default 5, width of the one-hot rate output.
REQ-005 SHALL have port clk, input, 1 bit, the single clock.
REQ-006 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-007 SHALL have port signal_i, input, 1 bit, raw biphase-mark S/PDIF line, asynchronous to clk.
REQ-008 SHALL have port locked_i, input, 1 bit, lock indication from the S/PDIF decoder.
REQ-009 SHALL have port clk_per_halfbit_o, output, MAX_CLK_PER_HALFBIT_LOG2 bits, half-bit period configuration for the decoder.
REQ-010 SHALL have port rate_o, output, NUM_RATE bits, one-hot rate with bit 0=32k, 1=44.1k, 2=48k, 3=96k, 4=192k.
REQ-011 SHALL have port relock_o, output, 1 bit, one-cycle decoder reset request.
REQ-012 SHALL have port valid_o, output, 1 bit, asserted while the decoder is locked at the applied rate.

Function
REQ-013 SHALL synchronise signal_i through two flops and detect both edges on the synchronised signal.
REQ-014 SHALL count clocks between consecutive edges in a 6-bit run counter that saturates at 63.
REQ-015 SHALL, per window, record the minimum completed run; runs below 3 count as glitches and are ignored.
REQ-016 SHALL, at window end, classify the minimum run: 3..5 gives 192k/4, 6..11 gives 96k/8, 12..16 gives 48k/16, 17..20 gives 44.1k/18, 21..28 gives 32k/24. Any other value, or a window with no valid run, gives no-match.
REQ-017 SHALL implement states MEASURE, CONFIRM, LOCKWAIT and TRACK, and SHALL enter MEASURE on reset.
REQ-018 MEASURE: a window with a match SHALL store the class and go to CONFIRM; no-match SHALL stay in MEASURE.
REQ-019 CONFIRM: the next window with the same class SHALL apply clk_per_halfbit_o/rate_o, pulse relock_o for exactly 1 cycle and go to LOCKWAIT. A different class SHALL replace the stored class and stay in CONFIRM; no-match SHALL go to MEASURE.
REQ-020 LOCKWAIT: locked_i=1 SHALL go to TRACK with valid_o=1 the next cycle; expiry of the timeout counter SHALL go to MEASURE.
REQ-021 TRACK: locked_i falling SHALL deassert valid_o the same cycle it is sampled and go to MEASURE; window results SHALL be ignored.
REQ-022 SHALL restart the window counter and minimum tracker on every entry to MEASURE.
REQ-023 SHALL hold clk_per_halfbit_o and rate_o at their last applied values outside CONFIRM->LOCKWAIT transitions.
REQ-024 SHALL keep rate_o strictly one-hot at all times.
REQ-025 If window end coincides with locked_i falling in TRACK, the unlock SHALL take priority.

Reset
REQ-026 SHALL, while rst_n=0, drive clk_per_halfbit_o=4, rate_o=5'b10000, relock_o=0 and valid_o=0.
REQ-027 SHALL, while rst_n=0, clear all counters, the synchroniser and the stored class.
REQ-028 SHALL restart in MEASURE with a fresh window on reset release, including release in the middle of a window.

Structure
REQ-029 SHALL place rate indices, the halfbit table {24,18,16,8,4} and the class bounds in shared package spdif_pkg.
REQ-030 SHALL place the synchroniser, edge detector, run counter and window minimum in sub-module spdif_runlen_meter, which outputs a window-done pulse and the minimum run.

Verification
REQ-031 Bench SHALL drive 48k biphase (16-clk half-bit) -> after 2 windows clk_per_halfbit_o=16, rate_o=5'b00100, one relock_o pulse; locked_i raised -> valid_o=1.
REQ-032 Bench SHALL hold the line idle for 3 windows -> remains in MEASURE, no relock_o, outputs stay 4/5'b10000.
REQ-033 Bench SHALL send one 44.1k window (18) then 32k windows (24) -> rate_o=5'b00001, clk_per_halfbit_o=24, exactly one relock_o pulse.
REQ-034 Bench SHALL apply 96k with locked_i held 0 -> relock_o, then timeout after 16384 clocks -> MEASURE, then second relock_o after two more windows.
REQ-035 Bench SHALL, in TRACK at 192k, drop locked_i -> valid_o=0 next cycle, and an injected 1-clk glitch SHALL NOT alter classification.
REQ-036 Bench SHALL assert rst_n=0 mid-LOCKWAIT -> all outputs at reset values immediately, with no relock_o pulse.
